// File: rtl/icache_pkg.sv
// Shared types and line geometry for the instruction-cache refill controller.
package icache_pkg;

  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int BEAT_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    FILL,
    REPLAY
  } state_t;

  function automatic logic [WORD_W-1:0] line_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, memory and fill signals of the refill controller bundled as one bus.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
);

  logic                        fetch_req;
  logic [ADDR_W-1:0]           pc;
  logic                        cache_hit;
  logic [ADDR_W-1:0]           cache_addr;
  logic                        stall;
  logic                        instr_valid;
  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ack;
  logic                        mem_rvalid;
  logic [31:0]                 mem_rdata;
  logic                        fill_we;
  logic [ADDR_W-1:0]           fill_addr;
  logic [32*WORDS_PER_LINE-1:0] fill_line;
  logic [31:0]                 miss_count;

  // The controller side is the master; fetch stage, cache and memory form the slave side.
  modport master (
    input  fetch_req, pc, cache_hit, mem_ack, mem_rvalid, mem_rdata,
    output cache_addr, stall, instr_valid, mem_req, mem_addr,
           fill_we, fill_addr, fill_line, miss_count
  );

  modport slave (
    output fetch_req, pc, cache_hit, mem_ack, mem_rvalid, mem_rdata,
    input  cache_addr, stall, instr_valid, mem_req, mem_addr,
           fill_we, fill_addr, fill_line, miss_count
  );

endinterface

// File: rtl/icache_line_assembler.sv
// Collects returned memory words into a cache line, one word slot per beat.
module icache_line_assembler
  import icache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              load,
  input  logic [WORD_W-1:0]                 wdata,
  output logic                              last_beat,
  output logic [WORD_W*WORDS_PER_LINE-1:0]  line
);

  localparam int BW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  logic [BW-1:0] beat;

  assign last_beat = (beat == BW'(WORDS_PER_LINE - 1));

  // Clear only rewinds the beat counter; every slot is overwritten before the line is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      line <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (load) begin
      line[beat*WORD_W +: WORD_W] <= wdata;
      beat                        <= beat + BW'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch, reads a line from memory beat by beat,
// writes it into the cache and replays the lookup.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input logic                  clk,
  input logic                  rst,
  icache_refill_ctrl_if.master bus
);

  state_t                            state;
  logic [ADDR_W-1:0]                 miss_addr;
  logic [ADDR_W-1:0]                 mem_addr_q;
  logic [ADDR_W-1:0]                 fill_addr_q;
  logic                              mem_req_q;
  logic                              fill_we_q;
  logic [31:0]                       miss_count_q;
  logic                              asm_clear;
  logic                              asm_load;
  logic                              last_beat;
  logic [WORD_W*WORDS_PER_LINE-1:0]  line;

  assign asm_clear = (state == REQ);
  assign asm_load  = (state == RECV) && bus.mem_rvalid;

  icache_line_assembler #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .load      (asm_load),
    .wdata     (bus.mem_rdata),
    .last_beat (last_beat),
    .line      (line)
  );

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_we    = fill_we_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_line  = line;
  assign bus.miss_count = miss_count_q;

  // Hit and replay outcomes must be visible in the same cycle as cache_hit.
  always_comb begin
    bus.cache_addr  = miss_addr;
    bus.stall       = 1'b1;
    bus.instr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cache_addr  = bus.pc;
        bus.instr_valid = bus.fetch_req && bus.cache_hit;
        bus.stall       = bus.fetch_req && !bus.cache_hit;
      end
      REPLAY: begin
        bus.instr_valid = bus.cache_hit;
        bus.stall       = !bus.cache_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      miss_addr    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_we_q    <= 1'b0;
      fill_addr_q  <= '0;
      miss_count_q <= '0;
    end else begin
      fill_we_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.fetch_req && !bus.cache_hit) begin
            miss_addr    <= bus.pc;
            mem_addr_q   <= line_align(bus.pc);
            mem_req_q    <= 1'b1;
            miss_count_q <= miss_count_q + 32'd1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= RECV;
          end
        end
        RECV: begin
          if (bus.mem_rvalid && last_beat) begin
            fill_we_q   <= 1'b1;
            fill_addr_q <= line_align(miss_addr);
            state       <= FILL;
          end
        end
        FILL: state <= REPLAY;
        REPLAY: begin
          // A miss on replay re-fetches the same line without counting a new miss.
          if (bus.cache_hit) begin
            state <= IDLE;
          end else begin
            mem_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed test-plan scenarios plus a
// randomized hit/miss mix checked against a line-level reference model.
module tb_icache_refill_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_miss_count = '0;
  logic [31:0] beat_data [4];

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.cache_hit  = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic random_beats();
    for (int k = 0; k < 4; k++) beat_data[k] = $urandom;
  endtask

  // First cycle of a miss: fetch in IDLE with the cache missing.
  task automatic miss_start(input logic [31:0] p);
    tick();
    idle_inputs();
    bus.fetch_req = 1'b1;
    bus.pc        = p;
    #1;
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b1000 ||
        bus.cache_addr !== p || bus.miss_count !== exp_miss_count) begin
      miscompares++;
      $display("[TB] FAIL miss_start: flags=%b cache_addr=%h miss_count=%0d, want 1000 %h %0d",
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.cache_addr,
               bus.miss_count, p, exp_miss_count);
    end
    exp_miss_count++;
  endtask

  // Drives REQ/RECV/FILL/REPLAY for one line read and checks every cycle.
  task automatic run_refill(input logic [31:0] p, input int ack_wait, input int gap,
                            input bit replay_hit, input bit toggle_pc);
    logic [31:0]  base;
    logic [127:0] exp_line;
    logic [3:0]   want;
    base = p & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = beat_data[k];

    for (int w = 0; w <= ack_wait; w++) begin
      tick();
      idle_inputs();
      bus.fetch_req  = 1'b1;
      bus.mem_ack    = (w == ack_wait);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      if (toggle_pc) bus.pc = $urandom & ~32'h3;
      #1;
      vectors++;
      if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b1010 ||
          bus.mem_addr !== base || bus.cache_addr !== p) begin
        miscompares++;
        $display("[TB] FAIL req: flags=%b mem_addr=%h cache_addr=%h, want 1010 %h %h",
                 {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.mem_addr,
                 bus.cache_addr, base, p);
      end
    end

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g <= gap; g++) begin
        tick();
        idle_inputs();
        bus.fetch_req  = 1'b1;
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.mem_rvalid = (g == gap);
        bus.mem_rdata  = (g == gap) ? beat_data[k] : $urandom;
        if (toggle_pc) bus.pc = $urandom & ~32'h3;
        #1;
        vectors++;
        if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b1000 ||
            bus.cache_addr !== p) begin
          miscompares++;
          $display("[TB] FAIL recv beat %0d: flags=%b cache_addr=%h, want 1000 %h",
                   k, {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we},
                   bus.cache_addr, p);
        end
      end
    end

    tick();
    idle_inputs();
    bus.fetch_req  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;
    #1;
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b1001 ||
        bus.fill_addr !== base || bus.fill_line !== exp_line) begin
      miscompares++;
      $display("[TB] FAIL fill: flags=%b fill_addr=%h fill_line=%h, want 1001 %h %h",
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.fill_addr,
               bus.fill_line, base, exp_line);
    end

    tick();
    idle_inputs();
    bus.fetch_req = 1'b1;
    bus.cache_hit = replay_hit;
    #1;
    want = {!replay_hit, replay_hit, 2'b00};
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== want ||
        bus.cache_addr !== p || bus.miss_count !== exp_miss_count) begin
      miscompares++;
      $display("[TB] FAIL replay: flags=%b cache_addr=%h miss_count=%0d, want %b %h %0d",
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.cache_addr,
               bus.miss_count, want, p, exp_miss_count);
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    idle_inputs();
    bus.mem_rvalid = 1'($urandom_range(0, 1));
    bus.mem_ack    = 1'($urandom_range(0, 1));
    #1;
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b0000 ||
        bus.miss_count !== exp_miss_count) begin
      miscompares++;
      $display("[TB] FAIL idle %s: flags=%b miss_count=%0d, want 0000 %0d", tag,
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.miss_count,
               exp_miss_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.pc = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b0000 ||
        bus.miss_count !== 32'd0 || bus.fill_line !== 128'd0 ||
        bus.mem_addr !== 32'd0 || bus.fill_addr !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset: flags=%b miss_count=%0d fill_line=%h mem_addr=%h fill_addr=%h, want all zero",
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.miss_count,
               bus.fill_line, bus.mem_addr, bus.fill_addr);
    end
    exp_miss_count = '0;
  endtask

  task automatic test_hit();
    logic [31:0] p;
    for (int i = 0; i < 5; i++) begin
      p = (i == 0) ? 32'h0000_0004 : ($urandom & ~32'h3);
      tick();
      idle_inputs();
      bus.fetch_req  = 1'b1;
      bus.cache_hit  = 1'b1;
      bus.pc         = p;
      bus.mem_ack    = 1'($urandom_range(0, 1));
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b0100 ||
          bus.cache_addr !== p || bus.miss_count !== exp_miss_count) begin
        miscompares++;
        $display("[TB] FAIL hit: flags=%b cache_addr=%h miss_count=%0d, want 0100 %h %0d",
                 {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.cache_addr,
                 bus.miss_count, p, exp_miss_count);
      end
    end
    idle_check("after hits");
  endtask

  task automatic test_cold_miss();
    for (int k = 0; k < 4; k++) beat_data[k] = 32'(4 * k);
    miss_start(32'h0000_0100);
    run_refill(32'h0000_0100, 0, 0, 1'b1, 1'b0);
    idle_check("after cold miss");
  endtask

  task automatic test_unaligned_miss();
    random_beats();
    miss_start(32'h0000_010C);
    run_refill(32'h0000_010C, 0, 0, 1'b1, 1'b0);
    idle_check("after unaligned miss");
  endtask

  task automatic test_stretched();
    logic [31:0] p;
    p = $urandom & ~32'h3;
    random_beats();
    miss_start(p);
    run_refill(p, 3, 2, 1'b1, 1'b1);
    idle_check("after stretched");
  endtask

  task automatic test_reset_mid_refill();
    random_beats();
    miss_start(32'h0000_2040);
    tick();
    idle_inputs();
    bus.fetch_req = 1'b1;
    bus.mem_ack   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      idle_inputs();
      bus.fetch_req  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beat_data[k];
    end
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_miss_count = '0;
    #1;
    vectors++;
    if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b0000 ||
        bus.miss_count !== 32'd0 || bus.fill_line !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL mid-refill reset: flags=%b miss_count=%0d fill_line=%h, want 0000 0 0",
               {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.miss_count,
               bus.fill_line);
    end
    for (int i = 0; i < 4; i++) idle_check("stray rvalid after reset");
  endtask

  task automatic test_replay_fault();
    logic [31:0] p;
    p = $urandom & ~32'h3;
    random_beats();
    miss_start(p);
    run_refill(p, 1, 0, 1'b0, 1'b0);
    random_beats();
    run_refill(p, 0, 1, 1'b1, 1'b0);
    idle_check("after replay fault");
  endtask

  task automatic test_random_mix();
    logic [31:0] p;
    for (int i = 0; i < 25; i++) begin
      p = $urandom & ~32'h3;
      if ($urandom_range(0, 2) == 0) begin
        tick();
        idle_inputs();
        bus.fetch_req = 1'b1;
        bus.cache_hit = 1'b1;
        bus.pc        = p;
        #1;
        vectors++;
        if ({bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we} !== 4'b0100 ||
            bus.cache_addr !== p) begin
          miscompares++;
          $display("[TB] FAIL random hit: flags=%b cache_addr=%h, want 0100 %h",
                   {bus.stall, bus.instr_valid, bus.mem_req, bus.fill_we}, bus.cache_addr, p);
        end
      end else begin
        random_beats();
        miss_start(p);
        if ($urandom_range(0, 3) == 0) begin
          run_refill(p, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b1);
          random_beats();
        end
        run_refill(p, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, 1'b1);
      end
      if ($urandom_range(0, 1) == 1) idle_check("random gap");
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.pc = '0;
    test_reset();
    test_hit();
    test_cold_miss();
    test_unaligned_miss();
    test_stretched();
    test_replay_fault();
    test_reset_mid_refill();
    test_hit();
    test_random_mix();
    idle_check("final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
